// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: round-robin between the C64 core and the data_io downloader.
// Define SDRAM_ARB_REFRESH_EN to add the periodic refresh counter and REFRESH state.
module sdram_arbiter #(
  parameter int unsigned ADDR_W           = 25,
  parameter int unsigned REFRESH_INTERVAL = 250
) (
  input  logic              clk32,
  input  logic              reset_n,
  input  logic              c64_req,
  input  logic              c64_we,
  input  logic [ADDR_W-1:0] c64_addr,
  input  logic [7:0]        c64_din,
  output logic              c64_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_din,
  output logic              io_ack,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_refresh,
  input  logic              ram_ready,
  output logic              grant_io
);

`ifdef SDRAM_ARB_REFRESH_EN
  typedef enum logic [1:0] {StIdle, StCmd, StWait, StRefresh} state_t;
`else
  typedef enum logic [1:0] {StIdle, StCmd, StWait} state_t;
`endif

  state_t              state_q, state_d;
  logic                owner_io_q, owner_io_d;
  logic                prio_io_q, prio_io_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_din_q, ram_din_d;
  logic                c64_ack_q, c64_ack_d;
  logic                io_ack_q, io_ack_d;
  logic                grant_io_q, grant_io_d;
  logic                pick_io;
  logic                ack_cycle;
  logic                wait_is_refresh;

  // On contention the pointer decides; a lone requester always wins.
  assign pick_io   = io_req & (~c64_req | prio_io_q);
  assign ack_cycle = c64_ack_q | io_ack_q;

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int unsigned CntW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [CntW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic            refresh_pending_q, refresh_pending_d;
  logic            refresh_op_q, refresh_op_d;
  logic            refresh_wrap;

  always_comb begin
    refresh_wrap      = (refresh_cnt_q == CntW'(REFRESH_INTERVAL - 1));
    refresh_cnt_d     = refresh_wrap ? '0 : refresh_cnt_q + CntW'(1);
    // A wrap while already pending collapses into the one outstanding refresh.
    refresh_pending_d = (refresh_pending_q & (state_q != StRefresh)) | refresh_wrap;
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt_q     <= '0;
      refresh_pending_q <= 1'b0;
      refresh_op_q      <= 1'b0;
    end else begin
      refresh_cnt_q     <= refresh_cnt_d;
      refresh_pending_q <= refresh_pending_d;
      refresh_op_q      <= refresh_op_d;
    end
  end

  assign wait_is_refresh = refresh_op_q;
  assign ram_refresh     = (state_q == StRefresh);
`else
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = ^REFRESH_INTERVAL;
  assign wait_is_refresh    = 1'b0;
  assign ram_refresh        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_io_d = owner_io_q;
    prio_io_d  = prio_io_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    c64_ack_d  = 1'b0;
    io_ack_d   = 1'b0;
    grant_io_d = grant_io_q & ~io_ack_q;
`ifdef SDRAM_ARB_REFRESH_EN
    refresh_op_d = refresh_op_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef SDRAM_ARB_REFRESH_EN
        if (refresh_pending_q) begin
          state_d      = StRefresh;
          refresh_op_d = 1'b1;
        end else
`endif
        // The requester just acked still holds req this cycle, so no grant yet.
        if (!ack_cycle && (c64_req || io_req)) begin
          state_d    = StCmd;
          owner_io_d = pick_io;
          prio_io_d  = ~pick_io;
          grant_io_d = pick_io;
          ram_we_d   = pick_io ? io_we   : c64_we;
          ram_addr_d = pick_io ? io_addr : c64_addr;
          ram_din_d  = pick_io ? io_din  : c64_din;
`ifdef SDRAM_ARB_REFRESH_EN
          refresh_op_d = 1'b0;
`endif
        end
      end
      StCmd: state_d = StWait;
      StWait: begin
        if (ram_ready) begin
          state_d = StIdle;
          if (!wait_is_refresh) begin
            c64_ack_d = ~owner_io_q;
            io_ack_d  = owner_io_q;
          end
        end
      end
`ifdef SDRAM_ARB_REFRESH_EN
      StRefresh: state_d = StWait;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      owner_io_q <= 1'b0;
      prio_io_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      c64_ack_q  <= 1'b0;
      io_ack_q   <= 1'b0;
      grant_io_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_io_q <= owner_io_d;
      prio_io_q  <= prio_io_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      c64_ack_q  <= c64_ack_d;
      io_ack_q   <= io_ack_d;
      grant_io_q <= grant_io_d;
    end
  end

  assign ram_req  = (state_q == StCmd);
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign c64_ack  = c64_ack_q;
  assign io_ack   = io_ack_q;
  assign grant_io = grant_io_q;

endmodule
